// File: rtl/mcu_gpio_wdt_ctrl.sv
// Fabric-side watchdog and reset sequencer for the EF2M45 hard MCU.
// Watches a firmware heartbeat on gpio_h0_out, pulses ppm_rstn on missed beats,
// and latches a sticky fault after repeated watchdog resets.
module mcu_gpio_wdt_ctrl #(
    parameter int unsigned TIMEOUT_CYC    = 1000000,
    parameter int unsigned BOOT_GRACE_CYC = 8000000,
    parameter int unsigned RST_PULSE_CYC  = 1024,
    parameter int unsigned MAX_RESETS     = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_fault_i,
    input  logic       hb_in_i,
    input  logic       hb_oe_n_i,
    output logic       ppm_rstn_o,
    output logic [3:0] mcu_status_o,
    output logic [1:0] reset_cnt_o,
    output logic       wdt_fault_o
);

    localparam int unsigned MaxTg  = (TIMEOUT_CYC > BOOT_GRACE_CYC) ? TIMEOUT_CYC : BOOT_GRACE_CYC;
    localparam int unsigned MaxCyc = (MaxTg > RST_PULSE_CYC) ? MaxTg : RST_PULSE_CYC;
    localparam int unsigned TimerW = $clog2(MaxCyc) + 1;

    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYC - 1);
    localparam logic [TimerW-1:0] GraceLast   = TimerW'(BOOT_GRACE_CYC - 1);
    localparam logic [TimerW-1:0] PulseLast   = TimerW'(RST_PULSE_CYC - 1);
    localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);
    localparam logic [1:0]        MaxResets   = 2'(MAX_RESETS);

    typedef enum logic [2:0] {
        StReset,
        StIdle,
        StBoot,
        StRun,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_wdt_q, last_wdt_d;
    logic              ppm_rstn_q, ppm_rstn_d;
    logic              fault_q, fault_d;
    logic [3:0]        status_q, status_d;

    logic hb_s1_q, hb_s2_q, hb_prev_q;
    logic oe_s1_q, oe_s2_q;
    logic hb_edge;
    logic timeout;

    // Two-flop synchronizers for the MCU heartbeat pins plus edge history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hb_s1_q   <= 1'b0;
            hb_s2_q   <= 1'b0;
            hb_prev_q <= 1'b0;
            oe_s1_q   <= 1'b1;
            oe_s2_q   <= 1'b1;
        end else begin
            hb_s1_q   <= hb_in_i;
            hb_s2_q   <= hb_s1_q;
            hb_prev_q <= hb_s2_q;
            oe_s1_q   <= hb_oe_n_i;
            oe_s2_q   <= oe_s1_q;
        end
    end

    // Any heartbeat level change counts, but only while the MCU drives the pin.
    assign hb_edge = (hb_s2_q ^ hb_prev_q) & ~oe_s2_q;

    // Next-state, timer, reset counter and output decode.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TimerOne;
        cnt_d      = cnt_q;
        last_wdt_d = last_wdt_q;
        timeout    = 1'b0;

        unique case (state_q)
            StReset: begin
                if (timer_q == PulseLast) begin
                    state_d = en_i ? StBoot : StIdle;
                end
            end
            StIdle: begin
                timer_d = '0;
                if (en_i) begin
                    state_d = StBoot;
                end
            end
            StBoot: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (hb_edge) begin
                    state_d = StRun;
                end else if (timer_q == GraceLast) begin
                    timeout = 1'b1;
                end
            end
            StRun: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (hb_edge) begin
                    timer_d = '0;
                end else if (timer_q == TimeoutLast) begin
                    timeout = 1'b1;
                end
            end
            StFault: begin
                timer_d = '0;
                if (clr_fault_i) begin
                    state_d    = StReset;
                    cnt_d      = 2'd0;
                    last_wdt_d = 1'b0;
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase

        // A timeout beats a coincident clr_fault.
        if (timeout) begin
            cnt_d      = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            last_wdt_d = 1'b1;
            state_d    = (cnt_d >= MaxResets) ? StFault : StReset;
        end else if (clr_fault_i && (state_q != StFault)) begin
            cnt_d      = 2'd0;
            last_wdt_d = 1'b0;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Outputs are decoded from the next state so they line up with it.
        ppm_rstn_d = (state_d == StIdle) || (state_d == StBoot) || (state_d == StRun);
        fault_d    = (state_d == StFault);
        status_d   = {cnt_d, last_wdt_d, ppm_rstn_d};
    end

    // State and registered outputs; async reset holds the MCU in reset at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StReset;
            timer_q    <= '0;
            cnt_q      <= 2'd0;
            last_wdt_q <= 1'b0;
            ppm_rstn_q <= 1'b0;
            fault_q    <= 1'b0;
            status_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            last_wdt_q <= last_wdt_d;
            ppm_rstn_q <= ppm_rstn_d;
            fault_q    <= fault_d;
            status_q   <= status_d;
        end
    end

    assign ppm_rstn_o   = ppm_rstn_q;
    assign wdt_fault_o  = fault_q;
    assign mcu_status_o = status_q;
    assign reset_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mcu_gpio_wdt_ctrl.sv
// Self-checking bench for mcu_gpio_wdt_ctrl: directed scenarios plus a random
// phase, all compared every cycle against a deadline-based behavioural model.
module tb_mcu_gpio_wdt_ctrl;

    localparam int Timeout = 16;
    localparam int Grace   = 32;
    localparam int Pulse   = 4;
    localparam int MaxRst  = 3;
    localparam int HistN   = 16384;

    localparam int MReset = 0;
    localparam int MIdle  = 1;
    localparam int MBoot  = 2;
    localparam int MRun   = 3;
    localparam int MFault = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       clr_fault = 1'b0;
    logic       hb = 1'b0;
    logic       oe_n = 1'b0;
    logic       ppm_rstn;
    logic [3:0] mcu_status;
    logic [1:0] reset_cnt;
    logic       wdt_fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: mode plus the edge index it was entered (or last kicked) at.
    int m_mode = MReset;
    int m_mark = 0;
    int m_cnt  = 0;
    bit m_lw   = 1'b0;
    int cyc    = 0;
    bit hb_h [HistN];
    bit oe_h [HistN];

    mcu_gpio_wdt_ctrl #(
        .TIMEOUT_CYC   (Timeout),
        .BOOT_GRACE_CYC(Grace),
        .RST_PULSE_CYC (Pulse),
        .MAX_RESETS    (MaxRst)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .clr_fault_i (clr_fault),
        .hb_in_i     (hb),
        .hb_oe_n_i   (oe_n),
        .ppm_rstn_o  (ppm_rstn),
        .mcu_status_o(mcu_status),
        .reset_cnt_o (reset_cnt),
        .wdt_fault_o (wdt_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void go(input int md);
        m_mode = md;
        m_mark = cyc;
    endfunction

    // Advance the model across one rising edge using the currently driven inputs.
    function automatic void model_step();
        bit hbe;
        bit to;
        int orig;
        cyc++;
        if (rst) begin
            m_mode = MReset;
            m_mark = cyc;
            m_cnt  = 0;
            m_lw   = 1'b0;
            hb_h[cyc] = 1'b0;
            oe_h[cyc] = 1'b1;
            return;
        end
        // A pin change sampled at edge k is acted on at edge k+2.
        hbe = (cyc >= 3) && (hb_h[cyc-2] != hb_h[cyc-3]) && !oe_h[cyc-2];
        hb_h[cyc] = hb;
        oe_h[cyc] = oe_n;
        to   = 1'b0;
        orig = m_mode;
        case (m_mode)
            MReset: if (cyc - m_mark == Pulse) go(en ? MBoot : MIdle);
            MIdle:  if (en) go(MBoot);
            MBoot: begin
                if (!en) go(MIdle);
                else if (hbe) go(MRun);
                else if (cyc - m_mark == Grace) to = 1'b1;
            end
            MRun: begin
                if (!en) go(MIdle);
                else if (hbe) m_mark = cyc;
                else if (cyc - m_mark == Timeout) to = 1'b1;
            end
            default: begin
                if (clr_fault) begin
                    go(MReset);
                    m_cnt = 0;
                    m_lw  = 1'b0;
                end
            end
        endcase
        if (to) begin
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            m_lw  = 1'b1;
            go((m_cnt >= MaxRst) ? MFault : MReset);
        end else if (clr_fault && orig != MFault) begin
            m_cnt = 0;
            m_lw  = 1'b0;
        end
    endfunction

    // One clock: update model, let the edge happen, compare on the falling edge.
    task automatic step();
        int alive;
        model_step();
        @(posedge clk);
        @(negedge clk);
        alive = (!rst && (m_mode == MIdle || m_mode == MBoot || m_mode == MRun)) ? 1 : 0;
        check("ppm_rstn", int'(ppm_rstn), alive);
        check("wdt_fault", int'(wdt_fault), (m_mode == MFault) ? 1 : 0);
        check("reset_cnt", int'(reset_cnt), m_cnt);
        check("mcu_status", int'(mcu_status), (m_cnt * 4) + (m_lw ? 2 : 0) + alive);
    endtask

    initial begin
        int n;
        int since;
        bit ok;

        hb_h[0] = 1'b0;
        oe_h[0] = 1'b1;

        // 1: reset release with en=1 gives a 4-cycle pulse, then BOOT.
        for (int i = 0; i < 3; i++) step();
        check("reset_ppm", int'(ppm_rstn), 0);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!ppm_rstn && n < 20);
        check("boot_pulse_len", n, Pulse);
        check("boot_status", int'(mcu_status), 4'b0001);

        // 2: steady heartbeat every 10 cycles keeps the MCU running.
        ok = 1'b1;
        since = 0;
        for (int i = 0; i < 500; i++) begin
            if (i % 10 == 0) begin
                hb = ~hb;
                since = 0;
            end
            step();
            since++;
            if (!ppm_rstn) ok = 1'b0;
        end
        check("hb_steady_alive", int'(ok), 1);
        check("hb_steady_cnt", int'(reset_cnt), 0);

        // 3: heartbeat stops; edge lands 3 cycles after the pin toggles, timeout 16 after.
        while (ppm_rstn && since < 60) begin
            step();
            since++;
        end
        check("hb_to_rstn_fall", since, 3 + Timeout);
        for (int i = 0; i < Pulse; i++) step();
        check("after_wdt_status", int'(mcu_status), 4'b0111);

        // 4: no heartbeat ever -> fault after the third timeout.
        n = 0;
        while (!wdt_fault && n < 400) begin
            step();
            n++;
        end
        check("fault_set", int'(wdt_fault), 1);
        check("fault_cnt", int'(reset_cnt), 3);
        for (int i = 0; i < 10; i++) step();
        check("fault_hold_rstn", int'(ppm_rstn), 0);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!ppm_rstn && n < 20);
        check("clr_pulse_len", n, Pulse);
        check("clr_cnt", int'(reset_cnt), 0);
        check("clr_fault", int'(wdt_fault), 0);

        // 5: edges with oe_n=1 are ignored -> grace timeout.
        oe_n = 1'b1;
        n = 0;
        while (ppm_rstn && n < 60) begin
            if (n % 5 == 0) hb = ~hb;
            step();
            n++;
        end
        check("grace_timeout", n, Grace);
        n = 0;
        while (!ppm_rstn && n < 20) begin
            step();
            n++;
        end
        // Heartbeat edge reaches the FSM exactly on the grace expiry edge.
        oe_n = 1'b0;
        ok = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            if (j == Grace - 2) hb = ~hb;
            step();
            if (!ppm_rstn) ok = 1'b0;
        end
        check("edge_at_expiry", int'(ok), 1);
        check("edge_at_expiry_cnt", int'(reset_cnt), 1);

        // 6: async reset mid-RUN, then en=0 in RUN.
        rst = 1'b1;
        #1;
        check("async_rst", int'(ppm_rstn), 0);
        step();
        step();
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!ppm_rstn && n < 20);
        check("rst_pulse_len", n, Pulse);
        hb = ~hb;
        for (int i = 0; i < 5; i++) step();
        en = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!ppm_rstn) ok = 1'b0;
        end
        check("idle_no_timeout", int'(ok), 1);
        check("idle_cnt", int'(reset_cnt), 0);
        en = 1'b1;

        // Random phase against the model.
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom % 16) != 0;
            clr_fault = ($urandom % 64) == 0;
            oe_n      = ($urandom % 10) == 0;
            rst       = ($urandom % 500) == 0;
            if ($urandom % 8 == 0) hb = ~hb;
            step();
        end
        rst = 1'b0;
        clr_fault = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
